// File: rtl/board_pkg.sv
// Shared definitions for the board control blocks.
// Holds the command op codes, response codes, the move-controller state
// encoding and the default board geometry so sibling blocks (e.g. the win
// detector) agree on the same dimensions.
package board_pkg;

  // Default geometry: register-file shape and legal board area.
  localparam int SIZE_DEF  = 16;
  localparam int DEPTH_DEF = 32;
  localparam int ROWS_DEF  = 9;
  localparam int COLS_DEF  = 9;

  // Command op codes (2'b10 and 2'b11 are illegal).
  localparam logic [1:0] OP_MOVE  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;

  // Response codes.
  localparam logic [1:0] RESP_OK       = 2'b00;
  localparam logic [1:0] RESP_OCCUPIED = 2'b01;
  localparam logic [1:0] RESP_BAD_ARG  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2,
    CLEAR = 2'd3
  } move_state_e;

endpackage

// File: rtl/board_move_ctrl.sv
// Move/clear sequencer in front of the 2R1W board register file; it is the
// only writer of that file.
//   clk, rst_n            : clock, asynchronous active-low reset
//   cmd_*                 : command handshake (op, row, col, player)
//   resp_valid/resp_code  : one-cycle response strobe and result code
//   busy                  : high whenever a command is in flight
//   rf_raddr0/1           : player-0 / player-1 row addresses
//   rf_read_data0/1       : combinational read data for those addresses
//   rf_waddr/rf_write_data/rf_write_en : registered write port
// A MOVE reads both players' bitmaps of the row, rejects illegal arguments
// or an occupied cell, and otherwise writes the mover's row back with the
// new bit set. A CLEAR writes zero to every entry, one per cycle.
module board_move_ctrl
  import board_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [$clog2(DEPTH)-2:0]   cmd_row,
  input  logic [$clog2(SIZE)-1:0]    cmd_col,
  input  logic                       cmd_player,
  output logic                       resp_valid,
  output logic [1:0]                 resp_code,
  output logic                       busy,
  output logic [$clog2(DEPTH)-1:0]   rf_raddr0,
  output logic [$clog2(DEPTH)-1:0]   rf_raddr1,
  input  logic [SIZE-1:0]            rf_read_data0,
  input  logic [SIZE-1:0]            rf_read_data1,
  output logic [$clog2(DEPTH)-1:0]   rf_waddr,
  output logic [SIZE-1:0]            rf_write_data,
  output logic                       rf_write_en
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(SIZE);
  localparam int HALF = DEPTH / 2;

  move_state_e       state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [CW-1:0]     col_q, col_d;
  logic              player_q, player_d;
  logic [AW-1:0]     rf_raddr0_q, rf_raddr0_d;
  logic [AW-1:0]     rf_raddr1_q, rf_raddr1_d;
  logic [AW-1:0]     rf_waddr_q, rf_waddr_d;
  logic [SIZE-1:0]   rf_write_data_q, rf_write_data_d;
  logic              rf_write_en_q, rf_write_en_d;
  logic              resp_valid_q, resp_valid_d;
  logic [1:0]        resp_code_q, resp_code_d;

  // Move evaluation, only meaningful in CHECK where the read data is valid.
  // The row under test lives in rf_raddr0_q (player-0 half, so it equals row).
  logic [SIZE-1:0] occ_row, mover_row, col_mask;
  logic            occupied, bad_arg;

  always_comb begin
    occ_row   = rf_read_data0 | rf_read_data1;
    mover_row = player_q ? rf_read_data1 : rf_read_data0;
    col_mask  = SIZE'(1) << col_q;
    occupied  = |(occ_row & col_mask);
    bad_arg   = (op_q != OP_MOVE) || (int'(rf_raddr0_q) >= ROWS) || (int'(col_q) >= COLS);
  end

  // NOTE: every _d starts as a copy of its _q so no path through the case
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    col_d           = col_q;
    player_d        = player_q;
    rf_raddr0_d     = rf_raddr0_q;
    rf_raddr1_d     = rf_raddr1_q;
    rf_waddr_d      = rf_waddr_q;
    rf_write_data_d = rf_write_data_q;
    rf_write_en_d   = rf_write_en_q;
    resp_valid_d    = resp_valid_q;
    resp_code_d     = resp_code_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          col_d    = cmd_col;
          player_d = cmd_player;
          if (cmd_op == OP_CLEAR) begin
            // rf_waddr doubles as the sweep counter; first write is next cycle.
            state_d         = CLEAR;
            rf_waddr_d      = '0;
            rf_write_data_d = '0;
            rf_write_en_d   = 1'b1;
          end else begin
            state_d     = CHECK;
            rf_raddr0_d = AW'(cmd_row);
            rf_raddr1_d = AW'(cmd_row) + AW'(HALF);
          end
        end
      end

      CHECK: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        if (bad_arg) begin
          resp_code_d = RESP_BAD_ARG;
        end else if (occupied) begin
          resp_code_d = RESP_OCCUPIED;
        end else begin
          resp_code_d     = RESP_OK;
          rf_waddr_d      = player_q ? rf_raddr1_q : rf_raddr0_q;
          rf_write_data_d = mover_row | col_mask;
          rf_write_en_d   = 1'b1;
        end
      end

      RESP: begin
        state_d       = IDLE;
        rf_write_en_d = 1'b0;
        resp_valid_d  = 1'b0;
      end

      CLEAR: begin
        if (rf_waddr_q == AW'(DEPTH - 1)) begin
          // Last write and the response were visible this cycle; the counter
          // wraps only here, so address DEPTH is never written.
          state_d       = IDLE;
          rf_waddr_d    = '0;
          rf_write_en_d = 1'b0;
          resp_valid_d  = 1'b0;
        end else begin
          rf_waddr_d = rf_waddr_q + AW'(1);
          // Response rides alongside the final write.
          if (rf_waddr_q == AW'(DEPTH - 2)) begin
            resp_valid_d = 1'b1;
            resp_code_d  = RESP_OK;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      op_q            <= OP_MOVE;
      col_q           <= '0;
      player_q        <= 1'b0;
      rf_raddr0_q     <= '0;
      rf_raddr1_q     <= '0;
      rf_waddr_q      <= '0;
      rf_write_data_q <= '0;
      rf_write_en_q   <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_code_q     <= RESP_OK;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      col_q           <= col_d;
      player_q        <= player_d;
      rf_raddr0_q     <= rf_raddr0_d;
      rf_raddr1_q     <= rf_raddr1_d;
      rf_waddr_q      <= rf_waddr_d;
      rf_write_data_q <= rf_write_data_d;
      rf_write_en_q   <= rf_write_en_d;
      resp_valid_q    <= resp_valid_d;
      resp_code_q     <= resp_code_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_code     = resp_code_q;
  assign rf_raddr0     = rf_raddr0_q;
  assign rf_raddr1     = rf_raddr1_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_write_data = rf_write_data_q;
  assign rf_write_en   = rf_write_en_q;

endmodule

// File: tb/tb_board_move_ctrl.sv
// Bench for board_move_ctrl: owns a 2R1W register file and an expected
// board image updated from the command rules (move/clear/reject).
module tb_board_move_ctrl;
  import board_pkg::*;

  localparam int SIZE  = 16;
  localparam int DEPTH = 32;
  localparam int HALF  = DEPTH / 2;
  localparam int ROWS  = 9;
  localparam int COLS  = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_row;
  logic [3:0]  cmd_col;
  logic        cmd_player;
  logic        resp_valid;
  logic [1:0]  resp_code;
  logic        busy;
  logic [4:0]  rf_raddr0, rf_raddr1, rf_waddr;
  logic [15:0] rf_read_data0, rf_read_data1, rf_write_data;
  logic        rf_write_en;

  logic [15:0] rf_mem  [DEPTH];
  logic [15:0] exp_mem [DEPTH];

  int checks = 0;
  int errors = 0;
  int we_in_idle = 0;

  always #5 clk = ~clk;

  board_move_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_player(cmd_player),
    .resp_valid(resp_valid), .resp_code(resp_code), .busy(busy),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
    .rf_read_data0(rf_read_data0), .rf_read_data1(rf_read_data1),
    .rf_waddr(rf_waddr), .rf_write_data(rf_write_data), .rf_write_en(rf_write_en)
  );

  // Register file: combinational reads, write commits on the clock edge.
  assign rf_read_data0 = rf_mem[rf_raddr0];
  assign rf_read_data1 = rf_mem[rf_raddr1];
  always @(posedge clk) if (rf_write_en) rf_mem[rf_waddr] <= rf_write_data;

  // A write strobe while the block claims to be ready is never legal.
  always @(negedge clk) if (rst_n && rf_write_en && cmd_ready) we_in_idle++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference rules: reject illegal op/coords, reject any set cell in the
  // row (either player), else set the mover's bit.
  function automatic logic [1:0] model_move(input logic [1:0] op, input int row,
                                            input int col, input int player);
    logic [15:0] both;
    if (op != 2'b00 || row >= ROWS || col >= COLS) return RESP_BAD_ARG;
    both = exp_mem[row] | exp_mem[row + HALF];
    if (both[col]) return RESP_OCCUPIED;
    exp_mem[player * HALF + row] = exp_mem[player * HALF + row] | (16'h1 << col);
    return RESP_OK;
  endfunction

  // Called at a negedge; returns at the negedge of cycle A+3.
  task automatic do_move(input logic [1:0] op, input int row, input int col,
                         input int player, input bit hold, output time acc_t);
    int n;
    int idx;
    logic [1:0] exp_code;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_row    = 4'(row);
    cmd_col    = 4'(col);
    cmd_player = 1'(player);
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("move_ready_timeout", 32'(n < 20), 32'd1);
    exp_code = model_move(op, row, col, player);
    idx = player * HALF + row;
    @(posedge clk);
    acc_t = $time;
    #1;
    // Scramble fields after acceptance; they must not matter.
    cmd_valid  = hold;
    cmd_op     = 2'($urandom);
    cmd_row    = 4'($urandom);
    cmd_col    = 4'($urandom);
    cmd_player = 1'($urandom);
    @(negedge clk);  // A+1: CHECK
    chk("chk_raddr0", 32'(rf_raddr0), 32'(row));
    chk("chk_raddr1", 32'(rf_raddr1), 32'(row + HALF));
    chk("chk_we_low", 32'(rf_write_en), 32'd0);
    chk("chk_busy", 32'(busy), 32'd1);
    @(negedge clk);  // A+2: RESP
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_code", 32'(resp_code), 32'(exp_code));
    chk("resp_we", 32'(rf_write_en), 32'(exp_code == RESP_OK));
    if (exp_code == RESP_OK) begin
      chk("resp_waddr", 32'(rf_waddr), 32'(idx));
      chk("resp_wdata", 32'(rf_write_data), 32'(exp_mem[idx]));
    end
    @(negedge clk);  // A+3: back in IDLE
    chk("idle_ready", 32'(cmd_ready), 32'd1);
    chk("idle_resp_low", 32'(resp_valid), 32'd0);
    chk("idle_we_low", 32'(rf_write_en), 32'd0);
    if (op == 2'b00 && row < HALF && col < SIZE)
      chk("row_contents", 32'(rf_mem[idx]), 32'(exp_mem[idx]));
  endtask

  // Starts a CLEAR at a negedge; sweeps (or aborts at abort_at) and checks.
  task automatic do_clear(input int abort_at);
    int n;
    int last;
    cmd_valid = 1'b1;
    cmd_op    = OP_CLEAR;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("clr_ready_timeout", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    last = (abort_at < 0) ? DEPTH - 1 : abort_at;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      chk("clr_we", 32'(rf_write_en), 32'd1);
      chk("clr_waddr", 32'(rf_waddr), 32'(k));
      chk("clr_wdata", 32'(rf_write_data), 32'd0);
      chk("clr_resp_valid", 32'(resp_valid), 32'(k == DEPTH - 1));
      if (k == DEPTH - 1) chk("clr_resp_code", 32'(resp_code), 32'(RESP_OK));
    end
    if (abort_at < 0) begin
      @(negedge clk);
      chk("clr_done_ready", 32'(cmd_ready), 32'd1);
      chk("clr_done_we", 32'(rf_write_en), 32'd0);
      chk("clr_done_resp", 32'(resp_valid), 32'd0);
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    end else begin
      rst_n = 1'b0;
      #1;
      chk("abort_we_async", 32'(rf_write_en), 32'd0);
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
      chk("abort_idle", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      chk("abort_no_resp2", 32'(resp_valid), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < abort_at; i++) exp_mem[i] = '0;
    end
    for (int i = 0; i < DEPTH; i++) chk("clr_mem", 32'(rf_mem[i]), 32'(exp_mem[i]));
  endtask

  initial begin
    time t0, t1, t2, t3;
    logic [1:0] rop;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_row    = '0;
    cmd_col    = '0;
    cmd_player = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rf_mem[i]  = 16'($urandom);
      exp_mem[i] = rf_mem[i];
    end
    @(negedge clk);
    @(negedge clk);
    // Reset values.
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_code", 32'(resp_code), 32'd0);
    chk("rst_raddr0", 32'(rf_raddr0), 32'd0);
    chk("rst_raddr1", 32'(rf_raddr1), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", 32'(rf_write_data), 32'd0);
    chk("rst_we", 32'(rf_write_en), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_clear(-1);

    // Directed moves.
    do_move(2'b00, 2, 4, 0, 1'b0, t0);
    chk("dir_first_write", 32'(rf_mem[2]), 32'h0010);
    do_move(2'b00, 2, 4, 1, 1'b0, t0);   // other player, same cell
    do_move(2'b00, 2, 4, 0, 1'b0, t0);   // same player, same cell
    do_move(2'b00, 2, 5, 0, 1'b0, t0);
    chk("dir_second_write", 32'(rf_mem[2]), 32'h0030);
    chk("dir_p1_row_empty", 32'(rf_mem[2 + HALF]), 32'h0000);

    // Boundary / illegal arguments.
    do_move(2'b00, 2, 9, 0, 1'b0, t0);
    do_move(2'b00, 9, 0, 1, 1'b0, t0);
    do_move(2'b11, 2, 4, 0, 1'b0, t0);
    do_move(2'b10, 3, 3, 1, 1'b0, t0);
    do_move(2'b00, 8, 8, 1, 1'b0, t0);   // last legal cell

    // Back-to-back with cmd_valid held high.
    do_move(2'b00, 0, 0, 0, 1'b1, t0);
    do_move(2'b00, 1, 1, 1, 1'b1, t1);
    do_move(2'b00, 0, 0, 1, 1'b1, t2);
    do_move(2'b00, 3, 7, 1, 1'b0, t3);
    chk("b2b_gap1", 32'(t1 - t0), 32'd30);
    chk("b2b_gap2", 32'(t2 - t1), 32'd30);
    chk("b2b_gap3", 32'(t3 - t2), 32'd30);

    // Randomized moves, mostly legal, some out of range or illegal op.
    for (int i = 0; i < 40; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
      do_move(rop, $urandom_range(0, 10), $urandom_range(0, 10),
              $urandom_range(0, 1), 1'($urandom), t0);
    end
    cmd_valid = 1'b0;

    // Reset mid-clear: fresh known contents, abort while address 10 is on the port.
    for (int i = 0; i < DEPTH; i++) begin
      rf_mem[i]  = 16'($urandom);
      exp_mem[i] = rf_mem[i];
    end
    do_clear(10);
    chk("we_never_in_idle", 32'(we_in_idle), 32'd0);

    // Block is usable after the abort.
    do_move(2'b00, 4, 2, 1, 1'b0, t0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
